alu_mc_exec: RTL and testbench
==============================

ALU_MC_EXEC -- requirements
Module: alu_mc_exec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the operand and result width in bits.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- arst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- alu_control  input  4  operation code.
- alu_in_0  input  DATA_W  operand A.
- alu_in_1  input  DATA_W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- alu_out  output  DATA_W  registered result.
- zero_flag  output  1  registered (alu_out == 0).

Function
REQ-003 The alu_control encoding SHALL be:
- AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, MUL=8.
- Codes 5 and 9-15 are illegal.
REQ-004 The FSM SHALL have three states: IDLE, MUL_RUN and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; it is driven combinationally from state.
REQ-006 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1. The opcode and operands are sampled only at acceptance; later input changes are ignored.
REQ-007 On accepting a non-MUL opcode, the block SHALL do the following in the same edge:
- Register the result and its zero_flag.
- Go to DONE, so out_valid=1 in the cycle after acceptance (latency 1).
REQ-008 Operation semantics:
- AND and OR: bitwise.
- ADD and SUB: modulo 2^DATA_W, no overflow flag.
- SLL and SRL: logical shift of A by B[log2(DATA_W)-1:0]; upper bits of B are ignored.
- SLT: signed compare, result 1 if A<B, else 0, zero-extended.
- MUL: low DATA_W bits of A*B.
- Illegal codes: result 0, zero_flag=1, same latency-1 handshake.
REQ-009 On accepting MUL, the block SHALL:
- Load mcand=A, mplier=B, acc=0, count=0.
- Enter MUL_RUN.
REQ-010 Each MUL_RUN cycle SHALL do one shift-add step, with no early termination:
- If mplier[0]=1: acc = acc + mcand (mod 2^DATA_W).
- mcand shifted left 1; mplier shifted right 1; count incremented.
REQ-011 The edge that completes step DATA_W SHALL:
- Load alu_out=acc and zero_flag.
- Go to DONE, so out_valid=1 exactly DATA_W+1 cycles after acceptance.
- The count width is clog2(DATA_W)+1.
REQ-012 In DONE:
- out_valid=1, and alu_out and zero_flag SHALL remain stable until out_ready=1.
- On an edge with out_ready=1, the block SHALL go to IDLE, and out_valid SHALL be 0 the next cycle.
REQ-013 The block SHALL NOT accept a new request in the same cycle as a result handshake; minimum spacing between acceptances is 2 cycles.
REQ-014 Ignored inputs:
- out_ready is ignored in IDLE and MUL_RUN.
- in_valid is ignored outside IDLE; the source holds the request until in_ready=1.
REQ-015 alu_out and zero_flag SHALL hold their last values in IDLE and MUL_RUN; they update only on the edge entering DONE.

Reset
REQ-016 While arst=1, regardless of clk, the outputs SHALL be:
- state = IDLE; out_valid = 0; in_ready = 1.
- alu_out = 0; zero_flag = 1.
- count = 0, and mcand, mplier and acc = 0.
REQ-017 Reset asserted mid-MUL_RUN or in DONE SHALL discard the operation and any pending result with no output. The first accepting edge after deassertion behaves as from power-up.

Verification
REQ-018 DATA_W=64, ADD A=5 B=7, out_ready=1 -> out_valid=1 the cycle after acceptance, alu_out=12, zero_flag=0, in_ready=1 one cycle later.
REQ-019 SUB A=3 B=3 -> alu_out=0, zero_flag=1; SUB A=0 B=1 -> alu_out=0xFFFF_FFFF_FFFF_FFFF.
REQ-020 Shifts, compares and illegal codes:
- SLT A=-1 B=1 -> alu_out=1.
- SLL A=1 B=65 -> alu_out=2.
- SRL A=0x8000_0000_0000_0000 B=63 -> alu_out=1.
- Opcode 5 -> alu_out=0.
REQ-021 MUL A=0xFFFF_FFFF_FFFF_FFFF B=3:
- alu_out=0xFFFF_FFFF_FFFF_FFFD, with out_valid rising exactly 65 cycles after acceptance.
- in_ready=0 throughout.
- in_valid pulses during the run are not accepted.
REQ-022 Backpressure: with out_ready=0 for 10 cycles in DONE, alu_out, zero_flag and out_valid stay constant and in_ready=0. Raising out_ready gives one handshake, then IDLE.
REQ-023 arst pulsed asynchronously 20 cycles into a MUL -> out_valid=0 and in_ready=1 immediately, with no result ever emitted. A following ADD A=1 B=1 yields alu_out=2 with latency 1.

Source files
------------

// File: rtl/alu_mc_exec.sv
// alu_mc_exec -- handshaked ALU with a multi-cycle shift-add multiplier.
//
// Single-cycle ops (AND, OR, ADD, SLL, SRL, SUB, SLT, illegal codes) register
// their result on the accepting edge and present it the following cycle.
// MUL runs DATA_W shift-add steps, one per cycle, with no early exit.
// The result is held in DONE until the consumer takes it with out_ready.
//
// Ports:
//   clk          rising-edge clock
//   arst         asynchronous active-high reset
//   in_valid     request valid            in_ready   request accepted (IDLE only)
//   alu_control  4-bit opcode             alu_in_0/1 operands A/B
//   out_valid    result valid (DONE)      out_ready  consumer takes result
//   alu_out      registered result        zero_flag  registered (alu_out == 0)
module alu_mc_exec #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [DATA_W-1:0]  mcand_r;
  logic [DATA_W-1:0]  mplier_r;
  logic [DATA_W-1:0]  acc_r;
  logic [CNT_W-1:0]   count_r;
  logic [DATA_W-1:0]  alu_res_s;
  logic [DATA_W-1:0]  acc_step_s;
  logic [SH_W-1:0]    shamt_s;
  logic               last_step_s;
  logic               accept_s;
  logic               is_mul_s;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b0}});
  endfunction

  assign shamt_s     = alu_in_1[SH_W-1:0];
  assign accept_s    = (state_r == IDLE) && in_valid;
  assign is_mul_s    = (alu_control == OP_MUL);
  // Step DATA_W is the one taken while count still reads DATA_W-1.
  assign last_step_s = (count_r == CNT_W'(DATA_W - 1));
  assign acc_step_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Single-cycle result for every non-MUL opcode; illegal codes give zero.
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    case (alu_control)
      OP_AND:  alu_res_s = alu_in_0 & alu_in_1;
      OP_OR:   alu_res_s = alu_in_0 | alu_in_1;
      OP_ADD:  alu_res_s = alu_in_0 + alu_in_1;
      OP_SLL:  alu_res_s = alu_in_0 << shamt_s;
      OP_SRL:  alu_res_s = alu_in_0 >> shamt_s;
      OP_SUB:  alu_res_s = alu_in_0 - alu_in_1;
      OP_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and handshake outputs, both decoded from the state register.
  always_comb begin
    state_nx_s = state_r;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx_s = is_mul_s ? MUL_RUN : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL_RUN: begin
        if (last_step_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = MUL_RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath: operand capture, shift-add steps and result registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mcand_r   <= {DATA_W{1'b0}};
      mplier_r  <= {DATA_W{1'b0}};
      acc_r     <= {DATA_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      alu_out   <= {DATA_W{1'b0}};
      zero_flag <= 1'b1;
    end else begin
      if (accept_s) begin
        if (is_mul_s) begin
          mcand_r  <= alu_in_0;
          mplier_r <= alu_in_1;
          acc_r    <= {DATA_W{1'b0}};
          count_r  <= {CNT_W{1'b0}};
        end else begin
          alu_out   <= alu_res_s;
          zero_flag <= is_zero(alu_res_s);
        end
      end else if (state_r == MUL_RUN) begin
        acc_r    <= acc_step_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        // The final step's sum goes straight to the output register.
        if (last_step_s) begin
          alu_out   <= acc_step_s;
          zero_flag <= is_zero(acc_step_s);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_exec.sv
// Scoreboard bench for alu_mc_exec: the stimulus process pushes hand-computed
// results into a queue at issue time; a monitor pops and compares whenever a
// result handshake (out_valid && out_ready) is presented.
module tb_alu_mc_exec;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_control;
  logic [W-1:0]  alu_in_0;
  logic [W-1:0]  alu_in_1;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_out;
  logic          zero_flag;

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  alu_mc_exec #(.DATA_W(W)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each handshaked result against the scoreboard head.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (arst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h required=none", alu_out);
        end else begin
          e = exp_q.pop_front();
          check("result", alu_out, e[W:1]);
          check("zero_flag", W'(zero_flag), W'(e[0]));
        end
      end
    end
  end

  // Issue one request, measure latency to out_valid, and (with out_ready=1)
  // confirm return to IDLE one cycle after the handshake.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] exp_res, input int lat);
    int n;
    int bad_rdy;
    exp_q.push_back({exp_res, (exp_res == {W{1'b0}})});
    alu_control = op;
    alu_in_0    = av;
    alu_in_1    = bv;
    in_valid    = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready_at_issue"}, W'(in_ready), W'(1'b1));
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not affect the result.
    in_valid    = 1'b0;
    alu_control = 4'd2;
    alu_in_0    = 64'hDEAD_BEEF_0BAD_F00D;
    alu_in_1    = 64'h1234_5678_9ABC_DEF0;
    n = 1;
    bad_rdy = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (in_ready !== 1'b0) bad_rdy++;
      if (n == 10) in_valid = 1'b1;
      if (n == 13) in_valid = 1'b0;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, W'(n), W'(lat));
    if (lat > 1) check({name, "_busy_not_ready"}, W'(bad_rdy), {W{1'b0}});
    if (out_ready) begin
      @(posedge clk); #1;
      check({name, "_back_to_idle"}, W'({in_ready, out_valid}), W'(2'b10));
    end
  endtask

  initial begin
    int bad;
    arst        = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 4'd0;
    alu_in_0    = {W{1'b0}};
    alu_in_1    = {W{1'b0}};
    #1;
    check("reset_out_valid", W'(out_valid), W'(1'b0));
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    check("reset_alu_out", alu_out, {W{1'b0}});
    check("reset_zero_flag", W'(zero_flag), W'(1'b1));
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk); #1;

    issue("add",     4'd2,  64'd5, 64'd7, 64'd12, 1);
    issue("sub_eq",  4'd6,  64'd3, 64'd3, 64'd0, 1);
    issue("sub_neg", 4'd6,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    issue("slt_t",   4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    issue("slt_f",   4'd7,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    issue("sll",     4'd3,  64'd1, 64'd65, 64'd2, 1);
    issue("srl",     4'd4,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
    issue("and",     4'd0,  64'hF0F0, 64'h0FF0, 64'h00F0, 1);
    issue("or",      4'd1,  64'hF0F0, 64'h0FF0, 64'hFFF0, 1);
    issue("ill5",    4'd5,  64'd9, 64'd4, 64'd0, 1);
    issue("ill15",   4'd15, 64'd9, 64'd4, 64'd0, 1);
    issue("mul_big", 4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    issue("mul_small", 4'd8, 64'd6, 64'd7, 64'd42, 65);

    // Backpressure: result must hold for 10 cycles with out_ready low.
    out_ready = 1'b0;
    issue("bp_add", 4'd2, 64'h10, 64'h20, 64'h30, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || alu_out !== 64'h30 || zero_flag !== 1'b0 || in_ready !== 1'b0)
        bad++;
    end
    check("bp_hold", W'(bad), {W{1'b0}});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", W'({in_ready, out_valid}), W'(2'b10));
    check("bp_result_held_in_idle", alu_out, 64'h30);

    // Asynchronous reset 20 cycles into a MUL: no result may ever appear.
    alu_control = 4'd8;
    alu_in_0    = 64'd11;
    alu_in_1    = 64'd13;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_out_valid", W'(out_valid), W'(1'b0));
    check("arst_in_ready", W'(in_ready), W'(1'b1));
    check("arst_alu_out", alu_out, {W{1'b0}});
    check("arst_zero_flag", W'(zero_flag), W'(1'b1));
    @(posedge clk); #1 arst = 1'b0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("arst_no_result", W'(bad), {W{1'b0}});
    issue("post_rst_add", 4'd2, 64'd1, 64'd1, 64'd2, 1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", W'(exp_q.size()), {W{1'b0}});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
